// File: rtl/icache_miss_arbiter.sv
// Two-port instruction-cache miss arbiter: one outstanding memory read,
// round-robin between subarrays, shared fill when both miss on the same line.
module icache_miss_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss0_valid,
    input  logic [ADDR_W-1:0] miss0_addr,
    output logic              miss0_ready,
    input  logic              miss1_valid,
    input  logic [ADDR_W-1:0] miss1_addr,
    output logic              miss1_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              fill_valid,
    output logic [1:0]        fill_mask,
    output logic [7:0]        fill_index,
    output logic [21:0]       fill_tag,
    output logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        mask_q;
    logic [DATA_W-1:0] data_q;

    logic same_line;
    logic grant0;
    logic grant1;
    logic rr_flip;
    logic idle_live;

    // Grants only exist in IDLE and are suppressed while reset is held.
    always_comb begin
        same_line = miss0_addr[ADDR_W-1:2] == miss1_addr[ADDR_W-1:2];
        idle_live = (state_q == IDLE) && rst_n;
        grant0    = 1'b0;
        grant1    = 1'b0;
        rr_flip   = 1'b0;
        if (idle_live) begin
            unique case (1'b1)
                miss0_valid && miss1_valid && same_line: begin
                    grant0 = 1'b1;
                    grant1 = 1'b1;
                end
                miss0_valid && miss1_valid && !same_line: begin
                    grant0  = !rr_q;
                    grant1  = rr_q;
                    rr_flip = 1'b1;
                end
                miss0_valid && !miss1_valid: grant0 = 1'b1;
                miss1_valid && !miss0_valid: grant1 = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        wcnt_d      = wcnt_q;
        timeout_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d = REQ;
                    if (rr_flip) rr_d = !rr_q;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d = FILL;
                end else if (wcnt_q == TO_CNT) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Datapath latches carry no reset; outputs below gate them by state.
    always_ff @(posedge clk) begin
        if (grant0 || grant1) begin
            addr_q <= grant0 ? miss0_addr : miss1_addr;
            mask_q <= {grant1, grant0};
        end
        if (state_q == WAIT && mem_resp_valid) begin
            data_q <= mem_resp_data;
        end
    end

    assign miss0_ready   = grant0;
    assign miss1_ready   = grant1;
    assign busy          = state_q != IDLE;
    assign mem_req_valid = state_q == REQ;
    assign mem_req_addr  = (state_q == REQ) ? (addr_q & ~ADDR_W'(3)) : '0;
    assign fill_valid    = state_q == FILL;
    assign fill_mask     = (state_q == FILL) ? mask_q : '0;
    assign fill_index    = (state_q == FILL) ? addr_q[9:2] : '0;
    assign fill_tag      = (state_q == FILL) ? addr_q[31:10] : '0;
    assign fill_data     = (state_q == FILL) ? data_q : '0;

endmodule

// File: tb/tb_icache_miss_arbiter.sv
// Randomised and directed bench for icache_miss_arbiter against a
// transaction-level reference model checked every cycle.
module tb_icache_miss_arbiter;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0v, m1v;
    logic [31:0] m0a, m1a;
    logic        m0r, m1r;
    logic        mqv;
    logic [31:0] mqa;
    logic        mrr, mrv;
    logic [31:0] mrd;
    logic        fv;
    logic [1:0]  fm;
    logic [7:0]  fi;
    logic [21:0] ft;
    logic [31:0] fd;
    logic        bsy, terr;

    int total = 0;
    int bad   = 0;

    icache_miss_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .miss0_valid(m0v), .miss0_addr(m0a), .miss0_ready(m0r),
        .miss1_valid(m1v), .miss1_addr(m1a), .miss1_ready(m1r),
        .mem_req_valid(mqv), .mem_req_addr(mqa), .mem_req_ready(mrr),
        .mem_resp_valid(mrv), .mem_resp_data(mrd),
        .fill_valid(fv), .fill_mask(fm), .fill_index(fi),
        .fill_tag(ft), .fill_data(fd),
        .busy(bsy), .timeout_err(terr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    // Reference model: one outstanding transaction record.
    logic        md_active, md_sent, md_have, md_rr;
    logic [31:0] md_addr, md_data;
    logic [1:0]  md_mask;
    int          md_wait;

    logic        e_r0, e_r1, e_qv, e_fv, e_bsy, e_to;
    logic [31:0] e_qa, e_fd;
    logic [1:0]  e_fm;
    logic [7:0]  e_fi;
    logic [21:0] e_ft;

    logic        s_r0, s_r1, s_qv, s_fv, s_bsy, s_to;
    logic [31:0] s_qa, s_fd;
    logic [1:0]  s_fm;
    logic [7:0]  s_fi;
    logic [21:0] s_ft;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic take(input logic [31:0] a, input logic [1:0] m);
        md_active = 1'b1;
        md_sent   = 1'b0;
        md_have   = 1'b0;
        md_addr   = a;
        md_mask   = m;
    endtask

    task automatic model();
        {e_r0, e_r1, e_qv, e_fv, e_bsy, e_to} = '0;
        e_qa = '0; e_fd = '0; e_fm = '0; e_fi = '0; e_ft = '0;
        if (!rst_n) begin
            md_active = 1'b0;
            md_rr     = 1'b0;
        end else begin
            e_bsy = md_active;
            if (!md_active) begin
                if (m0v && m1v && m0a[31:2] == m1a[31:2]) begin
                    e_r0 = 1'b1; e_r1 = 1'b1;
                    take(m0a, 2'b11);
                end else if (m0v && m1v) begin
                    if (!md_rr) begin e_r0 = 1'b1; take(m0a, 2'b01); end
                    else begin e_r1 = 1'b1; take(m1a, 2'b10); end
                    md_rr = !md_rr;
                end else if (m0v) begin
                    e_r0 = 1'b1; take(m0a, 2'b01);
                end else if (m1v) begin
                    e_r1 = 1'b1; take(m1a, 2'b10);
                end
            end else if (!md_sent) begin
                e_qv = 1'b1;
                e_qa = {md_addr[31:2], 2'b00};
                if (mrr) begin md_sent = 1'b1; md_wait = 0; end
            end else if (!md_have) begin
                if (mrv) begin
                    md_have = 1'b1; md_data = mrd;
                end else if (md_wait == TO) begin
                    e_to = 1'b1; md_active = 1'b0;
                end else begin
                    md_wait++;
                end
            end else begin
                e_fv = 1'b1; e_fm = md_mask;
                e_fi = md_addr[9:2]; e_ft = md_addr[31:10];
                e_fd = md_data; md_active = 1'b0;
            end
        end
    endtask

    // One clock: compare at the falling edge, then re-enter after rise.
    task automatic cyc();
        @(negedge clk);
        s_r0 = m0r; s_r1 = m1r; s_qv = mqv; s_qa = mqa; s_fv = fv;
        s_fm = fm; s_fi = fi; s_ft = ft; s_fd = fd; s_bsy = bsy; s_to = terr;
        model();
        check("miss0_ready", s_r0, e_r0);
        check("miss1_ready", s_r1, e_r1);
        check("mem_req_valid", s_qv, e_qv);
        check("mem_req_addr", s_qa, e_qa);
        check("fill_valid", s_fv, e_fv);
        check("fill_mask", s_fm, e_fm);
        check("fill_index", s_fi, e_fi);
        check("fill_tag", s_ft, e_ft);
        check("fill_data", s_fd, e_fd);
        check("busy", s_bsy, e_bsy);
        check("timeout_err", s_to, e_to);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {m0v, m1v, mrr, mrv} = '0;
        m0a = '0; m1a = '0; mrd = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic run_to_fill(input logic [31:0] d);
        int n;
        mrr = 1'b1; mrv = 1'b1; mrd = d;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!s_fv && n < 12);
        check("fill_reached", s_fv, 1'b1);
        mrv = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 2)
          | $urandom_range(0, 3);
        if ($urandom_range(0, 9) == 0) a = $urandom;
        return a;
    endfunction

    initial begin
        int  n;
        logic acc0, acc1;
        md_active = 1'b0; md_sent = 1'b0; md_have = 1'b0; md_rr = 1'b0;
        md_addr = '0; md_data = '0; md_mask = '0; md_wait = 0;
        rst_n = 1'b0;
        {m0v, m1v, mrr, mrv} = '0;
        m0a = '0; m1a = '0; mrd = '0;

        do_reset();
        cyc();
        check("rst_busy", s_bsy, 1'b0);
        check("rst_fill", s_fv, 1'b0);

        // Single miss, minimum latency.
        m0v = 1'b1; m0a = 32'h0000_1234; mrr = 1'b1;
        cyc();
        check("t0_ready0", s_r0, 1'b1);
        m0v = 1'b0;
        cyc();
        check("t1_req_valid", s_qv, 1'b1);
        check("t1_req_addr", s_qa, 32'h0000_1234);
        mrv = 1'b1; mrd = 32'hDEAD_BEEF;
        cyc();
        mrv = 1'b0;
        cyc();
        check("t3_fill_valid", s_fv, 1'b1);
        check("t3_mask", s_fm, 2'b01);
        check("t3_index", s_fi, 8'h8D);
        check("t3_tag", s_ft, 22'h000004);
        check("t3_data", s_fd, 32'hDEAD_BEEF);
        cyc();
        check("t4_idle", s_bsy, 1'b0);

        // Round robin, including back-to-back grants after FILL.
        do_reset();
        m0v = 1'b1; m0a = 32'h100; m1v = 1'b1; m1a = 32'h200;
        cyc();
        check("rr1_r0", s_r0, 1'b1);
        check("rr1_r1", s_r1, 1'b0);
        m0a = 32'h300;
        run_to_fill(32'h1111_1111);
        check("rr1_mask", s_fm, 2'b01);
        check("rr1_index", s_fi, 8'h40);
        mrv = 1'b0;
        cyc();
        check("rr2_r1", s_r1, 1'b1);
        check("rr2_r0", s_r0, 1'b0);
        m1v = 1'b0;
        run_to_fill(32'h2222_2222);
        check("rr2_mask", s_fm, 2'b10);
        check("rr2_index", s_fi, 8'h80);
        m1v = 1'b1; m1a = 32'h600;
        cyc();
        check("rr3_r0", s_r0, 1'b1);
        check("rr3_r1", s_r1, 1'b0);
        m0v = 1'b0;
        run_to_fill(32'h3333_3333);
        check("rr3_index", s_fi, 8'hC0);
        cyc();
        check("rr4_r1", s_r1, 1'b1);
        m1v = 1'b0;
        run_to_fill(32'h4444_4444);
        check("rr4_mask", s_fm, 2'b10);

        // Same line from both ports.
        do_reset();
        m0v = 1'b1; m0a = 32'h400; m1v = 1'b1; m1a = 32'h402; mrr = 1'b1;
        cyc();
        check("sl_r0", s_r0, 1'b1);
        check("sl_r1", s_r1, 1'b1);
        m0v = 1'b0; m1v = 1'b0;
        cyc();
        check("sl_req_addr", s_qa, 32'h400);
        run_to_fill(32'h5555_5555);
        check("sl_mask", s_fm, 2'b11);

        // Request back-pressure with stray responses.
        do_reset();
        m0v = 1'b1; m0a = 32'h1238; mrr = 1'b0;
        cyc();
        m0v = 1'b0; mrv = 1'b1; mrd = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_req_valid", s_qv, 1'b1);
            check("bp_req_addr", s_qa, 32'h1238);
        end
        mrr = 1'b1; mrv = 1'b0;
        cyc();
        check("bp_req_valid6", s_qv, 1'b1);
        run_to_fill(32'h6666_6666);
        check("bp_data", s_fd, 32'h6666_6666);

        // Timeout with the miss still held.
        do_reset();
        m0v = 1'b1; m0a = 32'h2000; mrr = 1'b1;
        cyc();
        cyc();
        n = 0;
        do begin
            cyc();
            n++;
        end while (!s_to && n < 300);
        check("to_wait_cycles", n, TO + 1);
        check("to_no_fill", s_fv, 1'b0);
        cyc();
        check("to_regrant", s_r0, 1'b1);
        m0v = 1'b0;
        run_to_fill(32'h7777_7777);

        // Reset while waiting, responses during and after reset.
        do_reset();
        m0v = 1'b1; m0a = 32'h3000; mrr = 1'b1;
        cyc();
        m0v = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0; mrv = 1'b1; mrd = 32'h8888_8888;
        cyc();
        check("mr_busy", s_bsy, 1'b0);
        check("mr_req", s_qv, 1'b0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("mr_no_fill", s_fv, 1'b0);
            check("mr_idle", s_bsy, 1'b0);
        end
        mrv = 1'b0;

        // Random traffic.
        acc0 = 1'b0; acc1 = 1'b0;
        for (int i = 0; i < 2400; i++) begin
            rst_n = $urandom_range(0, 249) != 0;
            if (!m0v || acc0) begin
                m0v = $urandom_range(0, 99) < 40;
                m0a = rand_addr();
            end
            if (!m1v || acc1) begin
                m1v = $urandom_range(0, 99) < 40;
                m1a = rand_addr();
            end
            mrr = 1'($urandom_range(0, 1));
            mrv = ((i % 800) < 300) ? 1'b0 : ($urandom_range(0, 99) < 30);
            mrd = $urandom;
            cyc();
            acc0 = e_r0;
            acc1 = e_r1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
